// File: rtl/vector_result_collector.sv
// Vector write-back collector: packs per-lane ALU results into one
// destination register image and issues a valid/ready register-file write.
module vector_result_collector #(
  parameter int VLEN        = 256,
  parameter int LONGEST_LEN = 64,
  parameter int LANE_NUM    = 2,
  parameter int VL_WIDTH    = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [VL_WIDTH-1:0]             vl,
  input  logic [2:0]                      cur_vsew,
  input  logic                            is_mask_operation,
  input  logic [VLEN-1:0]                 old_vd,
  input  logic                            lane_valid,
  output logic                            lane_ready,
  input  logic [LANE_NUM*LONGEST_LEN-1:0] lane_result,
  input  logic [LANE_NUM-1:0]             lane_active,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [VLEN-1:0]                 wb_data,
  output logic                            busy,
  output logic                            err
);

  localparam int IDXW = VL_WIDTH + 1;
  localparam int IW   = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [VLEN-1:0]     r_buf;
  logic [VLEN-1:0]     w_buf_nxt;
  logic [IDXW-1:0]     r_idx;
  logic [1:0]          r_vsew;
  logic                r_mask;
  logic [VL_WIDTH-1:0] r_vl_eff;
  logic                r_err;

  logic [VL_WIDTH-1:0] w_vlmax;
  logic [VL_WIDTH-1:0] w_vl_eff;
  logic                w_start_ok;
  logic                w_accept;
  logic                w_last;

  logic [IDXW-1:0]        w_e   [LANE_NUM];
  logic                   w_in  [LANE_NUM];
  logic [IW-1:0]          w_pos [LANE_NUM];
  logic [IW-1:0]          w_bit [LANE_NUM];
  logic [LONGEST_LEN-1:0] w_res [LANE_NUM];

  assign w_vlmax    = VL_WIDTH'(VLEN / 8) >> cur_vsew[1:0];
  assign w_vl_eff   = (vl > w_vlmax) ? w_vlmax : vl;
  assign w_start_ok = start && !cur_vsew[2];
  assign w_accept   = lane_valid && lane_ready;
  assign w_last     = (r_idx + IDXW'(LANE_NUM)) >= IDXW'(r_vl_eff);

  assign lane_ready = (r_state == COLLECT);
  assign wb_valid   = (r_state == WRITE);
  assign wb_data    = r_buf;
  assign busy       = (r_state != IDLE);
  assign err        = r_err;

  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    assign w_e[k]   = r_idx + IDXW'(k);
    assign w_in[k]  = (w_e[k] < IDXW'(r_vl_eff)) && lane_active[k];
    assign w_pos[k] = IW'(w_e[k] << (3 + r_vsew));
    assign w_bit[k] = IW'(w_e[k]);
    assign w_res[k] = lane_result[k*LONGEST_LEN +: LONGEST_LEN];
  end

  // Inactive and tail elements are simply left at their old_vd value.
  always_comb begin
    w_buf_nxt = r_buf;
    for (int k = 0; k < LANE_NUM; k++) begin
      if (w_in[k]) begin
        if (r_mask) begin
          w_buf_nxt[w_bit[k]] = w_res[k][0];
        end else begin
          case (r_vsew)
            2'd0:    w_buf_nxt[w_pos[k] +: 8]  = w_res[k][7:0];
            2'd1:    w_buf_nxt[w_pos[k] +: 16] = w_res[k][15:0];
            2'd2:    w_buf_nxt[w_pos[k] +: 32] = w_res[k][31:0];
            default: w_buf_nxt[w_pos[k] +: 64] = w_res[k][63:0];
          endcase
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok)
          w_state_nxt = (w_vl_eff == '0) ? WRITE : COLLECT;
      end
      COLLECT: begin
        if (w_accept && w_last)
          w_state_nxt = WRITE;
      end
      WRITE: begin
        if (wb_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_buf    <= '0;
      r_idx    <= '0;
      r_vsew   <= '0;
      r_mask   <= 1'b0;
      r_vl_eff <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= (r_state == IDLE) && start && cur_vsew[2];
      if (r_state == IDLE && w_start_ok) begin
        r_buf    <= old_vd;
        r_idx    <= '0;
        r_vsew   <= cur_vsew[1:0];
        r_mask   <= is_mask_operation;
        r_vl_eff <= w_vl_eff;
      end else if (r_state == COLLECT && w_accept) begin
        r_buf <= w_buf_nxt;
        r_idx <= r_idx + IDXW'(LANE_NUM);
      end
    end
  end

endmodule

// File: tb/tb_vector_result_collector.sv
// Directed bench for vector_result_collector: expected images go into a
// scoreboard queue at start; a monitor pops them on each write handshake.
module tb_vector_result_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [8:0]   vl;
  logic [2:0]   cur_vsew;
  logic         is_mask_operation;
  logic [255:0] old_vd;
  logic         lane_valid;
  logic         lane_ready;
  logic [127:0] lane_result;
  logic [1:0]   lane_active;
  logic         wb_valid;
  logic         wb_ready;
  logic [255:0] wb_data;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  logic [255:0] sb_q[$];
  logic [255:0] exp_img;

  vector_result_collector dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl),
    .cur_vsew(cur_vsew), .is_mask_operation(is_mask_operation),
    .old_vd(old_vd), .lane_valid(lane_valid), .lane_ready(lane_ready),
    .lane_result(lane_result), .lane_active(lane_active),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: beat counter and scoreboard comparison on write handshake.
  always @(negedge clk) begin
    if (!rst && lane_valid && lane_ready) beats++;
    if (!rst && wb_valid && wb_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h want none", wb_data);
      end else begin
        logic [255:0] e;
        e = sb_q.pop_front();
        if (wb_data !== e) begin
          errors++;
          $display("FAIL sb_data: got %h want %h", wb_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] s, input logic [8:0] n,
                          input logic m, input logic [255:0] old);
    cur_vsew = s;
    vl = n;
    is_mask_operation = m;
    old_vd = old;
    start = 1'b1;
    beats = 0;
    tick();
    start = 1'b0;
    old_vd = '1 ^ old;
    vl = 9'd7;
  endtask

  task automatic send_beat(input logic [63:0] r0, input logic [63:0] r1,
                           input logic [1:0] act);
    int n;
    lane_result = {r1, r0};
    lane_active = act;
    lane_valid = 1'b1;
    n = 0;
    while (!lane_ready && n < 20) begin
      tick();
      n++;
    end
    chk("beat_ready", 256'(lane_ready), 256'd1);
    tick();
    lane_valid = 1'b0;
    lane_result = {2{64'hFFFF_FFFF_FFFF_FFFF}};
  endtask

  task automatic do_write();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("wb_valid_drop", 256'(wb_valid), 256'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    vl = '0;
    cur_vsew = '0;
    is_mask_operation = 1'b0;
    old_vd = '0;
    lane_valid = 1'b0;
    lane_result = '0;
    lane_active = '0;
    wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lane_ready", 256'(lane_ready), 256'd0);
    chk("rst_wb_valid", 256'(wb_valid), 256'd0);
    chk("rst_wb_data", wb_data, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_err", 256'(err), 256'd0);
    rst = 1'b0;
    tick();

    // FOUR_BYTE, vl=5, three beats
    sb_q.push_back({{3{32'hFFFF_FFFF}}, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    do_start(3'b010, 9'd5, 1'b0, '1);
    chk("e32_ready_t1", 256'(lane_ready), 256'd1);
    send_beat(64'd1, 64'd2, 2'b11);
    send_beat(64'd3, 64'd4, 2'b11);
    send_beat(64'd5, 64'd6, 2'b11);
    chk("e32_wb_valid", 256'(wb_valid), 256'd1);
    chk("e32_ready_low", 256'(lane_ready), 256'd0);
    chk("e32_beats", 256'(beats), 256'd3);
    do_write();

    // ONE_BYTE, vl=4, alternating lane mask, upper result bits set
    sb_q.push_back(256'hAB00_00AB);
    do_start(3'b000, 9'd4, 1'b0, '0);
    send_beat(64'h1AB, 64'h1AB, 2'b01);
    send_beat(64'h1AB, 64'h1AB, 2'b10);
    chk("e8_beats", 256'(beats), 256'd2);
    do_write();

    // mask op, EIGHT_BYTE, vl=4, results 1,0,1,1
    exp_img = '1;
    exp_img[1] = 1'b0;
    sb_q.push_back(exp_img);
    do_start(3'b011, 9'd4, 1'b1, '1);
    send_beat(64'hFFFF_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFF0, 2'b11);
    send_beat(64'd1, 64'd1, 2'b11);
    do_write();

    // vl=0: direct write of old_vd
    exp_img = {8{32'h1357_9BDF}};
    sb_q.push_back(exp_img);
    do_start(3'b011, 9'd0, 1'b0, exp_img);
    chk("vl0_wb_valid", 256'(wb_valid), 256'd1);
    chk("vl0_no_ready", 256'(lane_ready), 256'd0);
    chk("vl0_data", wb_data, exp_img);
    do_write();

    // vl=300 on EIGHT_BYTE clips to 4 elements
    sb_q.push_back({64'd13, 64'd12, 64'd11, 64'd10});
    do_start(3'b011, 9'd300, 1'b0, '0);
    send_beat(64'd10, 64'd11, 2'b11);
    send_beat(64'd12, 64'd13, 2'b11);
    chk("clip_wb_valid", 256'(wb_valid), 256'd1);
    chk("clip_ready_low", 256'(lane_ready), 256'd0);
    chk("clip_beats", 256'(beats), 256'd2);
    do_write();

    // back-pressure: wb_ready low 5 cycles, start during WRITE ignored
    exp_img = {8{32'hA5A5_0F0F}};
    exp_img[31:0] = 32'h1111_DEF0;
    sb_q.push_back(exp_img);
    do_start(3'b001, 9'd2, 1'b0, {8{32'hA5A5_0F0F}});
    send_beat(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_0000_1111, 2'b11);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 256'(wb_valid), 256'd1);
      chk("bp_data", wb_data, exp_img);
      if (i == 2) begin
        cur_vsew = 3'b011;
        vl = 9'd0;
        old_vd = '0;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    do_write();
    chk("bp_idle", 256'(busy), 256'd0);

    // reset in the middle of a collection
    do_start(3'b011, 9'd4, 1'b0, {4{64'hCAFE_F00D_0000_0001}});
    send_beat(64'd7, 64'd8, 2'b11);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 256'(lane_ready), 256'd0);
    chk("mid_rst_wb_valid", 256'(wb_valid), 256'd0);
    chk("mid_rst_wb_data", wb_data, 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    tick();
    rst = 1'b0;
    tick();

    sb_q.push_back(256'h2211);
    do_start(3'b000, 9'd2, 1'b0, '0);
    send_beat(64'h311, 64'h422, 2'b11);
    do_write();

    // reserved vsew
    cur_vsew = 3'b100;
    vl = 9'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rsv_err", 256'(err), 256'd1);
    chk("rsv_busy", 256'(busy), 256'd0);
    tick();
    chk("rsv_err_pulse", 256'(err), 256'd0);
    chk("rsv_busy2", 256'(busy), 256'd0);

    repeat (3) tick();
    chk("sb_empty", 256'(sb_q.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
